qnt_engine: RTL and testbench

- Forward quantizer stage of the DCTQ datapath and the read-side initiator for the inverse-quantization ROM (byte-addressed, 64 x 8 bit, 1-cycle registered read).
- Accepts a stream of DCT coefficients in raster order, 64 per block.
- For each coefficient it issues the ROM address, multiplies the coefficient by the returned inverse-Q byte, then rounds and saturates.
- Emits quantized coefficients downstream with valid/ready backpressure.

---
 rtl/qnt_engine.sv | 168 ++++++++++++++++
 tb/tb_qnt_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qnt_engine.sv
// Forward quantizer stage: multiplies each DCT coefficient by its inverse-Q ROM byte,
// rounds half toward +inf, saturates, and streams results with valid/ready backpressure.
module qnt_engine #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    input  logic              in_last,
    output logic [5:0]        rom_a,
    input  logic [7:0]        rom_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [5:0]        out_idx,
    output logic              err_last
);

    localparam int PROD_W = COEF_W + 9;
    localparam int SHR_W  = PROD_W - FRAC_W;

    localparam logic signed [PROD_W-1:0] RND_HALF =
        {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [SHR_W-1:0] SAT_MAX =
        {{(SHR_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SHR_W-1:0] SAT_MIN =
        {{(SHR_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [5:0] LAST_IDX = 6'd63;

    // Add half an LSB then arithmetic shift: ties resolve toward +inf.
    function automatic logic signed [SHR_W-1:0] rnd_f(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] sum;
        sum = prod + RND_HALF;
        return SHR_W'(sum >>> FRAC_W);
    endfunction

    function automatic logic [OUT_W-1:0] sat_f(input logic signed [SHR_W-1:0] v);
        logic [OUT_W-1:0] res;
        if (v > SAT_MAX) begin
            res = OUT_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            res = OUT_W'(SAT_MIN);
        end else begin
            res = OUT_W'(v);
        end
        return res;
    endfunction

    logic [5:0]               idx_cnt_r;
    logic                     s1_valid_r;
    logic signed [COEF_W-1:0] s1_coef_r;
    logic [5:0]               s1_idx_r;
    logic                     out_valid_r;
    logic [OUT_W-1:0]         out_data_r;
    logic                     out_last_r;
    logic [5:0]               out_idx_r;
    logic                     err_last_r;

    logic                     advance_s;
    logic                     accept_s;
    logic                     in_ready_s;
    logic [5:0]               rom_a_s;
    logic signed [PROD_W-1:0] coef_ext_s;
    logic signed [PROD_W-1:0] rom_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [OUT_W-1:0]         q_s;

    // Handshake decode and ROM address select.
    always_comb begin
        advance_s  = 1'b0;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        rom_a_s    = idx_cnt_r;
        advance_s  = s1_valid_r && (!out_valid_r || out_ready);
        in_ready_s = !s1_valid_r || advance_s;
        accept_s   = in_valid && in_ready_s;
        // A stalled S1 keeps re-reading its own entry so rom_d stays aligned with it.
        if (s1_valid_r && !advance_s) begin
            rom_a_s = s1_idx_r;
        end else begin
            rom_a_s = idx_cnt_r;
        end
    end

    // Quantizer arithmetic on the S1 coefficient and the matching ROM byte.
    always_comb begin
        coef_ext_s = {{(PROD_W-COEF_W){s1_coef_r[COEF_W-1]}}, s1_coef_r};
        rom_ext_s  = {{(PROD_W-8){1'b0}}, rom_d};
        prod_s     = coef_ext_s * rom_ext_s;
        q_s        = sat_f(rnd_f(prod_s));
    end

    // Raster index counter with resync on a misplaced in_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt_r <= 6'd0;
        end else if (accept_s) begin
            if (in_last) begin
                idx_cnt_r <= 6'd0;
            end else begin
                idx_cnt_r <= idx_cnt_r + 6'd1;
            end
        end else begin
            idx_cnt_r <= idx_cnt_r;
        end
    end

    // Sticky framing error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_last_r <= 1'b0;
        end else if (accept_s && in_last && (idx_cnt_r != LAST_IDX)) begin
            err_last_r <= 1'b1;
        end else begin
            err_last_r <= err_last_r;
        end
    end

    // S1 capture stage: holds the coefficient while its ROM byte is fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_coef_r  <= '0;
            s1_idx_r   <= 6'd0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_coef_r  <= $signed(in_data);
            s1_idx_r   <= idx_cnt_r;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2 output register; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_idx_r   <= 6'd0;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= q_s;
            out_last_r  <= (s1_idx_r == LAST_IDX);
            out_idx_r   <= s1_idx_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign rom_a     = rom_a_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_idx   = out_idx_r;
    assign err_last  = err_last_r;

endmodule

// File: tb/tb_qnt_engine.sv
// Scoreboard bench for qnt_engine: a behavioural ROM plus an integer reference quantizer.
module tb_qnt_engine;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       in_data;
    logic              in_last;
    logic [5:0]        rom_a;
    logic [7:0]        rom_d = 8'd0;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [5:0]        out_idx;
    logic              err_last;

    qnt_engine #(.COEF_W(12), .OUT_W(8), .FRAC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .rom_a(rom_a), .rom_d(rom_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx), .err_last(err_last)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_tbl [64];
    always @(posedge clk) rom_d <= rom_tbl[rom_a];

    typedef struct {
        int         data;
        logic [5:0] idx;
        logic       last;
    } exp_t;
    exp_t sb_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_cnt  = 0;
    int         acc_cyc  = 0;
    int         stall_left = 0;
    logic [5:0] m_idx = 6'd0;
    logic       m_err = 1'b0;
    logic       lat_first = 1'b1;
    logic       lat_armed = 1'b0;
    logic       hold_chk  = 1'b0;
    int         hold_data = 0;
    int         hold_idx  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // floor((coef*r + 128) / 256), clamped to the signed 8-bit range
    function automatic int q_model(input int coef, input int r);
        int v;
        int q;
        v = coef * r + 128;
        if (v >= 0) q = v / 256;
        else        q = -((-v + 255) / 256);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic cycle(input logic v, input int d, input logic l, input logic ordy,
                         output logic acc);
        exp_t e;
        @(negedge clk);
        cyc_cnt++;
        in_valid  = v;
        in_data   = d[11:0];
        in_last   = l;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (hold_chk) begin
            check_val("hold_valid", int'(out_valid), 1);
            check_val("hold_data", int'($signed(out_data)), hold_data);
            check_val("hold_idx", int'(out_idx), hold_idx);
        end
        check_val("err_last", int'(err_last), int'(m_err));
        if (sb_q.size() == 0) begin
            check_val("idle_rom_a", int'(rom_a), int'(m_idx));
            check_val("idle_in_ready", int'(in_ready), 1);
            check_val("idle_out_valid", int'(out_valid), 0);
        end
        if (sb_q.size() == 2 && !out_ready) begin
            check_val("stall_in_ready", int'(in_ready), 0);
            check_val("stall_rom_a", int'(rom_a), int'(sb_q[1].idx));
        end
        if (lat_armed && out_valid) begin
            check_val("latency", cyc_cnt - acc_cyc, 2);
            lat_armed = 1'b0;
        end
        hold_chk  = out_valid && !out_ready;
        hold_data = int'($signed(out_data));
        hold_idx  = int'(out_idx);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("out_data", int'($signed(out_data)), e.data);
                check_val("out_idx", int'(out_idx), int'(e.idx));
                check_val("out_last", int'(out_last), int'(e.last));
            end
        end
        if (in_valid && in_ready) begin
            acc    = 1'b1;
            e.data = q_model(int'($signed(in_data)), int'(rom_tbl[m_idx]));
            e.idx  = m_idx;
            e.last = (m_idx == 6'd63);
            sb_q.push_back(e);
            if (lat_first) begin
                acc_cyc   = cyc_cnt;
                lat_armed = 1'b1;
                lat_first = 1'b0;
            end
            if (in_last && m_idx != 6'd63) m_err = 1'b1;
            m_idx = in_last ? 6'd0 : m_idx + 6'd1;
        end
    endtask

    // Offer one beat until accepted; rdy_pct is the out_ready probability in percent.
    task automatic send_beat(input int d, input logic l, input int rdy_pct);
        logic acc;
        logic ordy;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            if (stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end else begin
                ordy = ($urandom_range(0, 99) < rdy_pct);
            end
            cycle(1'b1, d, l, ordy, acc);
            tries++;
        end
        if (!acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_rom_a", int'(rom_a), 0);
        check_val("rst_err_last", int'(err_last), 0);
        sb_q.delete();
        m_idx     = 6'd0;
        m_err     = 1'b0;
        hold_chk  = 1'b0;
        lat_first = 1'b1;
        lat_armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        int   d;
        for (int i = 0; i < 64; i++) rom_tbl[i] = 8'((i * 37 + 11) % 256);
        rom_tbl[0]  = 8'hFF;
        rom_tbl[7]  = 8'h3C;
        rom_tbl[63] = 8'h19;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_val("reset_out_valid", int'(out_valid), 0);
        check_val("reset_out_data", int'(out_data), 0);
        check_val("reset_out_idx", int'(out_idx), 0);
        check_val("reset_out_last", int'(out_last), 0);
        check_val("reset_err_last", int'(err_last), 0);
        check_val("reset_in_ready", int'(in_ready), 1);
        check_val("reset_rom_a", int'(rom_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Block 1: constant 100, consumer always ready
        for (int i = 0; i < 64; i++) send_beat(100, (i == 63), 100);

        // Block 2: rounding and positive saturation, random backpressure
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? 2047 : (i == 7) ? 512 : (i == 63) ? -300 : $urandom_range(0, 4095) - 2048;
            send_beat(d, (i == 63), 70);
        end

        // Block 3: negative saturation and a 5-cycle consumer stall mid-block
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? -2048 : $urandom_range(0, 4095) - 2048;
            if (i == 20) stall_left = 5;
            send_beat(d, (i == 63), 100);
        end

        // Misplaced in_last at index 40, then blocks with idle gaps
        for (int i = 0; i <= 40; i++) send_beat($urandom_range(0, 4095) - 2048, (i == 40), 100);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) cycle(1'b0, $urandom_range(0, 4095), 1'b1, 1'b1, acc);
                send_beat($urandom_range(0, 4095) - 2048, (i == 63), 60);
            end
        end

        // Fill S1 and S2, then reset mid-block
        for (int i = 0; i < 3; i++) cycle(1'b1, 5, 1'b0, 1'b0, acc);
        check_val("pre_rst_full", sb_q.size(), 2);
        apply_reset();
        for (int i = 0; i < 10; i++) send_beat($urandom_range(0, 4095) - 2048, 1'b0, 80);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) cycle(1'b0, 0, 1'b0, 1'b1, acc);
        check_val("drain_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
